pipeline_hazard_ctrl: RTL and testbench

Pipeline control unit that sequences the IF/ID pipeline register, the PC and the ID/EX register of the 5-stage datapath. It detects load-use and RAW hazards, taken branches and multi-cycle EX operations. It drives stall (hold), flush and bubble controls for one cycle or for a counted multi-cycle window. It also keeps a saturating stall-cycle counter for performance measurement.

---
 rtl/pipeline_ctrl_pkg.sv | 24 ++
 rtl/raw_hazard_cmp.sv | 22 ++
 rtl/pipeline_hazard_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Holds the FSM state enum, the register-zero constant and the control bundle.
package pipeline_ctrl_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_MULT = 1'b1
    } hzd_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_write;
        logic fd_write;
        logic fd_flush;
        logic de_bubble;
    } ctrl_bundle_t;

    // Register 0 is hard-wired to zero, so it can never carry a dependency.
    function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
        return (src == dst) && (dst != REG_ZERO);
    endfunction

endpackage

// File: rtl/raw_hazard_cmp.sv
// Source/destination comparator for one producer stage, with register-0 masking.
// Flags a hit when a read source of the ID instruction matches a written destination.
module raw_hazard_cmp
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] i_rs,
    input  logic [4:0] i_rt,
    input  logic       i_uses_rs,
    input  logic       i_uses_rt,
    input  logic [4:0] i_rd,
    input  logic       i_rd_write,
    output logic       o_hit
);

    logic w_rs_hit;
    logic w_rt_hit;

    assign w_rs_hit = i_uses_rs & reg_match(i_rs, i_rd);
    assign w_rt_hit = i_uses_rt & reg_match(i_rt, i_rd);
    assign o_hit    = i_rd_write & (w_rs_hit | w_rt_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/bubble sequencing for PC, IF/ID and ID/EX,
// plus a saturating stall counter. Define HZD_FORWARD_EN when a forwarding unit exists.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MULT_LAT = 4,
    parameter int CNT_W    = 16
)(
    input  logic             Clk,
    input  logic             Rst,
    input  logic [4:0]       IDRs,
    input  logic [4:0]       IDRt,
    input  logic             IDUsesRs,
    input  logic             IDUsesRt,
    input  logic             IDMultiCycle,
    input  logic [4:0]       EXRd,
    input  logic             EXRegWrite,
    input  logic             EXMemRead,
    input  logic [4:0]       MEMRd,
    input  logic             MEMRegWrite,
    input  logic             EXBranchTaken,
    output logic             PCWrite,
    output logic             FDWrite,
    output logic             FDFlush,
    output logic             DEBubble,
    output logic             Busy,
    output logic [CNT_W-1:0] StallCnt
);

    localparam logic [3:0]       MULT_REM_INIT = 4'(MULT_LAT - 1);
    localparam bit               MULT_EN       = (MULT_LAT > 1);
    localparam logic [CNT_W-1:0] CNT_MAX       = {CNT_W{1'b1}};

    hzd_state_e       r_state;
    hzd_state_e       w_next_state;
    logic [3:0]       r_rem;
    logic [3:0]       w_next_rem;
    logic [CNT_W-1:0] r_stall_cnt;
    ctrl_bundle_t     w_ctrl;
    logic             w_busy;
    logic             w_ex_hit;
    logic             w_load_use;
    logic             w_stall;

    raw_hazard_cmp u_cmp_ex (
        .i_rs       (IDRs),
        .i_rt       (IDRt),
        .i_uses_rs  (IDUsesRs),
        .i_uses_rt  (IDUsesRt),
        .i_rd       (EXRd),
        .i_rd_write (EXRegWrite),
        .o_hit      (w_ex_hit)
    );

    assign w_load_use = EXMemRead & w_ex_hit;

`ifdef HZD_FORWARD_EN
    logic w_unused_mem;
    assign w_unused_mem = ^{MEMRd, MEMRegWrite};
    assign w_stall      = w_load_use;
`else
    logic w_mem_hit;

    raw_hazard_cmp u_cmp_mem (
        .i_rs       (IDRs),
        .i_rt       (IDRt),
        .i_uses_rs  (IDUsesRs),
        .i_uses_rt  (IDUsesRt),
        .i_rd       (MEMRd),
        .i_rd_write (MEMRegWrite),
        .o_hit      (w_mem_hit)
    );

    // Without forwarding every RAW dependency stalls until the producer retires.
    assign w_stall = w_load_use | w_ex_hit | w_mem_hit;
`endif

    // State, remaining-cycle and stall counter registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state     <= ST_RUN;
            r_rem       <= 4'd0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            r_rem   <= w_next_rem;
            if (!w_ctrl.fd_write && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
        end
    end

    // Next-state and Mealy control outputs; reset forces a flushed, frozen front end.
    always_comb begin
        w_ctrl       = '{pc_write: 1'b0, fd_write: 1'b0, fd_flush: 1'b0, de_bubble: 1'b0};
        w_busy       = 1'b0;
        w_next_state = r_state;
        w_next_rem   = r_rem;
        if (Rst) begin
            w_ctrl       = '{pc_write: 1'b0, fd_write: 1'b0, fd_flush: 1'b1, de_bubble: 1'b1};
            w_next_state = ST_RUN;
            w_next_rem   = 4'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (EXBranchTaken) begin
                        w_ctrl = '{pc_write: 1'b1, fd_write: 1'b1, fd_flush: 1'b1, de_bubble: 1'b1};
                    end else if (w_stall) begin
                        w_ctrl = '{pc_write: 1'b0, fd_write: 1'b0, fd_flush: 1'b0, de_bubble: 1'b1};
                    end else begin
                        w_ctrl = '{pc_write: 1'b1, fd_write: 1'b1, fd_flush: 1'b0, de_bubble: 1'b0};
                        if (IDMultiCycle && MULT_EN) begin
                            w_next_state = ST_MULT;
                            w_next_rem   = MULT_REM_INIT;
                        end else begin
                            w_next_state = ST_RUN;
                        end
                    end
                end
                ST_MULT: begin
                    // EX is occupied by the multi-cycle op, so a branch cannot resolve here.
                    w_ctrl = '{pc_write: 1'b0, fd_write: 1'b0, fd_flush: 1'b0, de_bubble: 1'b1};
                    w_busy = 1'b1;
                    if (r_rem <= 4'd1) begin
                        w_next_state = ST_RUN;
                        w_next_rem   = 4'd0;
                    end else begin
                        w_next_rem   = r_rem - 4'd1;
                    end
                end
                default: begin
                    w_next_state = ST_RUN;
                    w_next_rem   = 4'd0;
                end
            endcase
        end
    end

    assign PCWrite  = w_ctrl.pc_write;
    assign FDWrite  = w_ctrl.fd_write;
    assign FDFlush  = w_ctrl.fd_flush;
    assign DEBubble = w_ctrl.de_bubble;
    assign Busy     = w_busy;
    assign StallCnt = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: per-cycle expectations pushed to a
// scoreboard queue at drive time and compared mid-cycle against the Mealy outputs.
module tb_pipeline_hazard_ctrl;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [4:0]  IDRs = 5'd0, IDRt = 5'd0, EXRd = 5'd0, MEMRd = 5'd0;
    logic        IDUsesRs = 1'b0, IDUsesRt = 1'b0, IDMultiCycle = 1'b0;
    logic        EXRegWrite = 1'b0, EXMemRead = 1'b0, MEMRegWrite = 1'b0, EXBranchTaken = 1'b0;
    logic        PCWrite, FDWrite, FDFlush, DEBubble, Busy;
    logic [15:0] StallCnt;

    pipeline_hazard_ctrl #(.MULT_LAT(4), .CNT_W(16)) dut (
        .Clk(Clk), .Rst(Rst), .IDRs(IDRs), .IDRt(IDRt), .IDUsesRs(IDUsesRs), .IDUsesRt(IDUsesRt),
        .IDMultiCycle(IDMultiCycle), .EXRd(EXRd), .EXRegWrite(EXRegWrite), .EXMemRead(EXMemRead),
        .MEMRd(MEMRd), .MEMRegWrite(MEMRegWrite), .EXBranchTaken(EXBranchTaken),
        .PCWrite(PCWrite), .FDWrite(FDWrite), .FDFlush(FDFlush), .DEBubble(DEBubble),
        .Busy(Busy), .StallCnt(StallCnt)
    );

    always #5 Clk = ~Clk;

    // Control vector order: {PCWrite, FDWrite, FDFlush, DEBubble, Busy}
    localparam logic [4:0] C_RUN    = 5'b11000;
    localparam logic [4:0] C_STALL  = 5'b00010;
    localparam logic [4:0] C_BRANCH = 5'b11110;
    localparam logic [4:0] C_MULT   = 5'b00011;
    localparam logic [4:0] C_RESET  = 5'b00110;

`ifdef HZD_FORWARD_EN
    localparam logic [4:0] C_RAW = C_RUN;
`else
    localparam logic [4:0] C_RAW = C_STALL;
`endif

    typedef struct packed {
        logic       rst;
        logic [4:0] rs, rt;
        logic       urs, urt, mc;
        logic [4:0] exrd;
        logic       exw, exm;
        logic [4:0] memrd;
        logic       memw, br;
        logic [4:0] ctl;
    } row_t;

    typedef struct packed {
        logic [4:0]  ctl;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] exp_cnt = 16'd0;
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic row_t idle(input logic [4:0] ctl);
        row_t r;
        r     = '0;
        r.ctl = ctl;
        return r;
    endfunction

    function automatic row_t load_use(input logic [4:0] rd, input logic [4:0] ctl);
        row_t r;
        r      = idle(ctl);
        r.rs   = rd;
        r.urs  = 1'b1;
        r.exrd = rd;
        r.exw  = 1'b1;
        r.exm  = 1'b1;
        return r;
    endfunction

    // Drives one cycle of stimulus and pushes what the outputs must be during it.
    task automatic apply(input row_t r);
        Rst = r.rst; IDRs = r.rs; IDRt = r.rt; IDUsesRs = r.urs; IDUsesRt = r.urt;
        IDMultiCycle = r.mc; EXRd = r.exrd; EXRegWrite = r.exw; EXMemRead = r.exm;
        MEMRd = r.memrd; MEMRegWrite = r.memw; EXBranchTaken = r.br;
        sb.push_back('{ctl: r.ctl, cnt: exp_cnt});
        if (r.rst) exp_cnt = 16'd0;
        else if (!r.ctl[3] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic run_rows(input string name, input row_t rows[$]);
        exp_t e;
        for (int i = 0; i < rows.size(); i++) begin
            apply(rows[i]);
            @(negedge Clk);
            e = sb.pop_front();
            n_cmp++;
            if ({PCWrite, FDWrite, FDFlush, DEBubble, Busy} !== e.ctl) begin
                n_err++;
                $display("FAIL %s ctl cyc%0d: got %b want %b", name, i,
                         {PCWrite, FDWrite, FDFlush, DEBubble, Busy}, e.ctl);
            end
            n_cmp++;
            if (StallCnt !== e.cnt) begin
                n_err++;
                $display("FAIL %s cnt cyc%0d: got %0d want %0d", name, i, StallCnt, e.cnt);
            end
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic test_reset();
        row_t q[$];
        row_t r;
        r = idle(C_RESET); r.rst = 1'b1; r.mc = 1'b1; r.br = 1'b1;
        q.push_back(r);
        q.push_back(idle(C_RUN));
        run_rows("reset", q);
    endtask

    task automatic test_load_use();
        row_t q[$];
        row_t r;
        q.push_back(load_use(5'd5, C_STALL));
        // Load has moved to MEM; only a non-forwarding build still sees a dependency.
        r = idle(C_RAW); r.rs = 5'd5; r.urs = 1'b1; r.memrd = 5'd5; r.memw = 1'b1;
        q.push_back(r);
        q.push_back(idle(C_RUN));
        run_rows("load_use", q);
    endtask

    task automatic test_reg_zero();
        row_t q[$];
        row_t r;
        q.push_back(load_use(5'd0, C_RUN));
        r = load_use(5'd9, C_RUN); r.urs = 1'b0;
        q.push_back(r);
        r = load_use(5'd9, C_STALL); r.rs = 5'd1; r.urs = 1'b0; r.rt = 5'd9; r.urt = 1'b1;
        q.push_back(r);
        run_rows("reg_zero", q);
    endtask

    task automatic test_mult();
        row_t q[$];
        row_t r;
        r = idle(C_RUN); r.mc = 1'b1;
        q.push_back(r);
        q.push_back(idle(C_MULT));
        r = idle(C_MULT); r.br = 1'b1;
        q.push_back(r);
        q.push_back(idle(C_MULT));
        q.push_back(idle(C_RUN));
        run_rows("mult", q);
    endtask

    task automatic test_branch();
        row_t q[$];
        row_t r;
        r = load_use(5'd5, C_BRANCH); r.br = 1'b1; r.mc = 1'b1;
        q.push_back(r);
        q.push_back(idle(C_RUN));
        run_rows("branch", q);
    endtask

    task automatic test_stall_then_mult();
        row_t q[$];
        row_t r;
        r = load_use(5'd4, C_STALL); r.mc = 1'b1;
        q.push_back(r);
        r = idle(C_RUN); r.mc = 1'b1;
        q.push_back(r);
        for (int i = 0; i < 3; i++) q.push_back(idle(C_MULT));
        q.push_back(idle(C_RUN));
        run_rows("stall_then_mult", q);
    endtask

    task automatic test_mult_reset();
        row_t q[$];
        row_t r;
        r = idle(C_RUN); r.mc = 1'b1;
        q.push_back(r);
        q.push_back(idle(C_MULT));
        r = idle(C_RESET); r.rst = 1'b1;
        q.push_back(r);
        q.push_back(idle(C_RUN));
        run_rows("mult_reset", q);
    endtask

    task automatic test_raw_forward_cfg();
        row_t q[$];
        row_t r;
        r = idle(C_RAW); r.rt = 5'd7; r.urt = 1'b1; r.memrd = 5'd7; r.memw = 1'b1;
        q.push_back(r);
        q.push_back(idle(C_RUN));
        r = idle(C_RAW); r.rs = 5'd3; r.urs = 1'b1; r.exrd = 5'd3; r.exw = 1'b1;
        q.push_back(r);
        r = idle(C_RUN); r.rt = 5'd7; r.urt = 1'b1; r.memrd = 5'd0; r.memw = 1'b1; r.rs = 5'd0;
        q.push_back(r);
        run_rows("raw_cfg", q);
    endtask

    task automatic test_back_to_back();
        row_t q[$];
        row_t r;
        q.push_back(load_use(5'd2, C_STALL));
        r = load_use(5'd6, C_BRANCH); r.br = 1'b1;
        q.push_back(r);
        q.push_back(load_use(5'd8, C_STALL));
        q.push_back(idle(C_RUN));
        run_rows("back_to_back", q);
    endtask

    initial begin
        repeat (2) @(posedge Clk);
        #1;
        exp_cnt = 16'd0;
        test_reset();
        test_load_use();
        test_reg_zero();
        test_mult();
        test_branch();
        test_stall_then_mult();
        test_mult_reset();
        test_raw_forward_cfg();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
